// File: rtl/gpr_writeback.sv
// GPR write-port merger: ALU results win the port, long results queue in a FIFO.
// Optional GPR_WB_BYPASS_EN: an accepted long result skips an empty FIFO when the port is free.
module gpr_writeback #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 32,
  parameter  int AW    = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we,
  input  logic [AW-1:0]     alu_rd,
  input  logic [DW-1:0]     alu_data,
  input  logic              lng_valid,
  output logic              lng_ready,
  input  logic [AW-1:0]     lng_rd,
  input  logic [DW-1:0]     lng_data,
  output logic              Sw,
  output logic [AW-1:0]     Sc,
  output logic [DW-1:0]     Sin,
  output logic [2**AW-1:0]  busy,
  output logic [CW-1:0]     count
);

  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  logic alu_w;
  logic full;
  logic empty;
  logic head_live;
  logic accept;
  logic lng_nz;
  logic byp;
  logic push;
  logic pop;
  logic drain;

  assign alu_w     = alu_we && (alu_rd != '0);
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign head_live = !empty && live_q[rd_ptr];
  assign lng_ready = !full && !rst;
  assign accept    = lng_valid && lng_ready;
  assign lng_nz    = (lng_rd != '0);

`ifdef GPR_WB_BYPASS_EN
  assign byp = accept && lng_nz && empty && !alu_w;
`else
  assign byp = 1'b0;
`endif

  assign push  = accept && lng_nz && !byp;
  assign drain = head_live && !alu_w;
  // A dead head leaves without using the port, even under an ALU write.
  assign pop   = !empty && (!head_live || !alu_w);

  always_comb begin
    Sw  = 1'b0;
    Sc  = '0;
    Sin = '0;
    if (!rst) begin
      unique case (1'b1)
        alu_w: begin
          Sw  = 1'b1;
          Sc  = alu_rd;
          Sin = alu_data;
        end
        drain: begin
          Sw  = 1'b1;
          Sc  = rd_q[rd_ptr];
          Sin = data_q[rd_ptr];
        end
        byp: begin
          Sw  = 1'b1;
          Sc  = lng_rd;
          Sin = lng_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      live_q <= '0;
    end else begin
      // Older queued results to the same register are superseded.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_w && (rd_q[i] == alu_rd)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
      end
      if (push) begin
        live_q[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= lng_rd;
      data_q[wr_ptr] <= lng_data;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) busy[rd_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
    if (rst) busy = '0;
  end

  assign count = rst ? '0 : cnt;

endmodule

// File: tb/tb_gpr_writeback.sv
// Randomized scoreboard bench for gpr_writeback against a queue-based model.
// Builds with or without GPR_WB_BYPASS_EN.
module tb_gpr_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lng_valid = 1'b0;
  logic        lng_ready;
  logic [4:0]  lng_rd = '0;
  logic [31:0] lng_data = '0;
  logic        Sw;
  logic [4:0]  Sc;
  logic [31:0] Sin;
  logic [31:0] busy;
  logic [2:0]  count;

  always #5 clk = ~clk;

  gpr_writeback dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
    .lng_valid(lng_valid), .lng_ready(lng_ready),
    .lng_rd(lng_rd), .lng_data(lng_data),
    .Sw(Sw), .Sc(Sc), .Sin(Sin),
    .busy(busy), .count(count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          live;
  } ent_t;

  typedef struct {
    logic        sw;
    logic [4:0]  sc;
    logic [31:0] sin;
    logic [2:0]  cnt;
    logic        rdy;
    logic [31:0] busy;
  } exp_t;

  ent_t mq[$];
  exp_t expq[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] busy_of();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) if (mq[i].live) b[mq[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic step(input bit r, input bit aw, input logic [4:0] ar,
                      input logic [31:0] ad, input bit lv,
                      input logic [4:0] lr, input logic [31:0] ld);
    exp_t e;
    bit aluw, rdy, acc, byp, pop;
    ent_t t;
    @(negedge clk);
    rst = r; alu_we = aw; alu_rd = ar; alu_data = ad;
    lng_valid = lv; lng_rd = lr; lng_data = ld;
    e.sw = 0; e.sc = '0; e.sin = '0; e.cnt = '0; e.rdy = 0; e.busy = '0;
    if (r) begin
      mq.delete();
    end else begin
      aluw = aw && (ar != 0);
      rdy = mq.size() < 4;
      e.rdy = rdy;
      e.cnt = 3'(mq.size());
      e.busy = busy_of();
      acc = lv && rdy;
      byp = 0;
`ifdef GPR_WB_BYPASS_EN
      byp = acc && (lr != 0) && (mq.size() == 0) && !aluw;
`endif
      if (aluw) begin
        e.sw = 1; e.sc = ar; e.sin = ad;
      end else if (mq.size() > 0 && mq[0].live) begin
        e.sw = 1; e.sc = mq[0].rd; e.sin = mq[0].d;
      end else if (byp) begin
        e.sw = 1; e.sc = lr; e.sin = ld;
      end
      pop = (mq.size() > 0) && (!mq[0].live || !aluw);
      if (pop) void'(mq.pop_front());
      if (aluw) foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 0;
      if (acc && (lr != 0) && !byp) begin
        t.rd = lr; t.d = ld; t.live = 1;
        mq.push_back(t);
      end
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        ok = (Sw === e.sw) && (count === e.cnt) && (lng_ready === e.rdy)
          && (busy === e.busy)
          && (!e.sw || ((Sc === e.sc) && (Sin === e.sin)))
          && (!rst || ((Sc === 5'd0) && (Sin === 32'd0)));
        if (!ok) begin
          bad++;
          $display("FAIL cycle t=%0t: got Sw=%0b Sc=%0d Sin=%h cnt=%0d rdy=%0b busy=%h, want Sw=%0b Sc=%0d Sin=%h cnt=%0d rdy=%0b busy=%h",
                   $time, Sw, Sc, Sin, count, lng_ready, busy,
                   e.sw, e.sc, e.sin, e.cnt, e.rdy, e.busy);
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 5, 32'h55);
    step(0, 1, 3, 32'hA, 1, 5, 32'hB);
    idle(3);
    for (int i = 0; i < 6; i++) step(0, 1, 1, i, 1, 5'(8 + i), 32'(100 + i));
    idle(6);
    step(0, 0, 0, 0, 1, 7, 32'h11);
    step(0, 1, 7, 32'h22, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 1, i, 1, 5'(9 + i), 32'(200 + i));
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);
    @(negedge clk);
    #5;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected cycles unchecked, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
